obstacle_scan_ctrl: RTL and testbench
=====================================

Name: obstacle_scan_ctrl

Overview:
- Navigation controller directly downstream of the ultrasonic ranger; consumes its distance samples and produces the 2-bit motor command for the motor driver decode.
- Arms on a motion-sensor rising edge, then drives forward.
- On an obstacle it stops and sweeps right 90° then left 180°, tracking the heading with the longest echo, and turns to that heading before resuming forward.
- Also drives the alert (LED/speaker) enable.

Parameters:
- DIST_W, 16, width of distance sample in cm.
- OBST_CM, 25, obstacle threshold; dist < OBST_CM is blocked.
- TURN90_CYC, 27_500_000, clk cycles of turning per 90° (50 MHz clk).
- SETTLE_CYC, 5_000_000, stop/settle time after obstacle detection.
- HEAD_W, 32, signed heading counter width; must hold ±3*TURN90_CYC.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- motion  in  1  raw PIR output, asynchronous to clk.
- dist_valid  in  1  one-cycle strobe, new sample on dist_cm.
- dist_cm  in  DIST_W  ranger distance; all-ones means no echo (treated as maximum).
- motor_cmd  out  2  00 STOP, 01 RIGHT, 10 LEFT, 11 FWD.
- active  out  1  high from arming until reset; drives beep/blink enable.
- scanning  out  1  high in SCAN_R, SCAN_L, ALIGN.
- best_dist  out  DIST_W  largest distance captured in the current/last sweep (debug/HEX).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, motor_cmd=00, active=0, scanning=0, best_dist=0.
  - heading=0, timer=0.
  - Motion synchronizer flops and edge-history flop reset to 1, so motion held high through reset does not arm; a low then a high is required.
- Motion path: 2-FF synchronizer plus rising-edge detect. The arm pulse occurs 3 clk after motion rises. Ignored once active=1.
- Registered outputs: all outputs change one cycle after the state/timer event that causes them.
- IDLE: motor 00.
  - Arm pulse -> FWD, active<=1.
- FWD: motor 11.
  - dist_valid with dist_cm < OBST_CM -> SETTLE, timer<=0.
  - dist_cm == OBST_CM is not blocked.
- SETTLE: motor 00 for SETTLE_CYC cycles.
  - Then best_dist<=0, best_head<=0, heading<=0 -> SCAN_R.
- SCAN_R: motor 01 for TURN90_CYC cycles; heading +1 per cycle.
  - On dist_valid with dist_cm > best_dist (strict; ties keep the earlier heading): best_dist<=dist_cm, best_head<=heading.
  - At expiry -> SCAN_L.
- SCAN_L: motor 10 for 2*TURN90_CYC cycles; heading -1 per cycle; same capture rule.
  - Final heading = -TURN90_CYC.
  - At expiry: if best_dist >= OBST_CM, target<=best_head; else target<=-2*TURN90_CYC (net 180° turn-around). Then -> ALIGN.
- ALIGN: motor 01 if heading<target, 10 if heading>target; heading moves toward target by 1 per cycle.
  - heading==target -> FWD; heading<=0.
  - If heading already equals target on entry, ALIGN lasts exactly 1 cycle with motor 00.
- Simultaneous events:
  - A dist_valid on the same cycle as timer expiry is captured in the expiring state, using that cycle's heading.
  - A dist_valid in SETTLE or ALIGN is ignored.
  - Obstacle samples are evaluated only in FWD.
- Arithmetic:
  - Timer is unsigned, width ceil(log2(2*TURN90_CYC+1)), and never wraps (compare-and-clear).
  - heading/target are signed HEAD_W.
  - Distance compares are unsigned.
- No return to IDLE without reset; active stays 1.
- Reset mid-turn: motor_cmd goes to 00 asynchronously with rst_n low.

Decomposition:
- Package robot_pkg: motor command constants (MOT_STOP, MOT_RIGHT, MOT_LEFT, MOT_FWD), FSM state enum (IDLE, FWD, SETTLE, SCAN_R, SCAN_L, ALIGN), shared DIST_W default.
- Sub-module motion_edge_sync: 2-FF synchronizer plus rise detect with reset value 1; outputs a one-cycle arm pulse. Reused for other async sensor inputs.

Test Plan (TURN90_CYC=100, SETTLE_CYC=10, OBST_CM=25):
- Reset with motion=1, release, hold 50 cycles -> motor_cmd=00, active=0. Drop motion, raise it -> active=1 and motor_cmd=11 within 4 cycles of the rise.
- In FWD, dist_valid with dist=25 -> stays 11. dist=24 -> 00 for 10 cycles, then 01 for 100 cycles.
- Sweep samples: 40 at SCAN_R cycle 30, 90 at SCAN_L cycle 150 (heading -50), 90 again later -> best_dist=90. ALIGN shows 10 for 0 cycles (heading -100 → target -50 needs RIGHT): 01 for 50 cycles, then 11.
- All sweep samples < 25 (max 20) -> after SCAN_L, motor 10 for 100 cycles (heading -100 → -200), then 11; best_dist=20.
- dist_valid=300 coincident with the last SCAN_R cycle -> captured with best_head=+99; ALIGN drives 01 for 199 cycles.
- Assert rst_n mid SCAN_L -> motor_cmd=00 immediately (same cycle, async), active=0, best_dist=0; re-arming requires a new motion edge.

Source files
------------

// File: rtl/robot_pkg.sv
// Types and constants shared by the navigation controller and its bench.
package robot_pkg;

   localparam int DIST_W_DEF = 16;

   typedef logic [1:0] mot_t;

   localparam mot_t MOT_STOP  = 2'b00;
   localparam mot_t MOT_RIGHT = 2'b01;
   localparam mot_t MOT_LEFT  = 2'b10;
   localparam mot_t MOT_FWD   = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      FWD,
      SETTLE,
      SCAN_R,
      SCAN_L,
      ALIGN
   } state_t;

endpackage

// File: rtl/obstacle_scan_ctrl_if.sv
// Ranger sample input and motor/status outputs of the navigation controller.
interface obstacle_scan_ctrl_if
   import robot_pkg::*;
#(
   parameter int DIST_W = DIST_W_DEF
) ();

   logic              dist_valid;
   logic [DIST_W-1:0] dist_cm;
   mot_t              motor_cmd;
   logic              active;
   logic              scanning;
   logic [DIST_W-1:0] best_dist;

   modport master (
      output dist_valid,
      output dist_cm,
      input  motor_cmd,
      input  active,
      input  scanning,
      input  best_dist
   );

   modport slave (
      input  dist_valid,
      input  dist_cm,
      output motor_cmd,
      output active,
      output scanning,
      output best_dist
   );

endinterface

// File: rtl/motion_edge_sync.sv
// Two-flop synchronizer with registered rising-edge pulse for async sensors.
module motion_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic pulse_o
);

   logic s1_q;
   logic s2_q;
   logic hist_q;
   logic pulse_q;

   // Resetting to 1 means a level held high through reset is not an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         hist_q  <= 1'b1;
         pulse_q <= 1'b0;
      end else begin
         s1_q    <= async_i;
         s2_q    <= s1_q;
         hist_q  <= s2_q;
         pulse_q <= s2_q & ~hist_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/obstacle_scan_ctrl.sv
// Drive forward, stop on obstacle, sweep for the longest echo, turn to it.
module obstacle_scan_ctrl
   import robot_pkg::*;
#(
   parameter int DIST_W     = DIST_W_DEF,
   parameter int OBST_CM    = 25,
   parameter int TURN90_CYC = 27_500_000,
   parameter int SETTLE_CYC = 5_000_000,
   parameter int HEAD_W     = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic motion,
   obstacle_scan_ctrl_if.slave bus
);

   localparam int TMAX = (2 * TURN90_CYC > SETTLE_CYC) ?
                         2 * TURN90_CYC : SETTLE_CYC;
   localparam int TW   = $clog2(TMAX + 1);

   typedef logic [TW-1:0]            tmr_t;
   typedef logic signed [HEAD_W-1:0] head_t;
   typedef logic [DIST_W-1:0]        dist_t;

   localparam tmr_t  T_SET  = tmr_t'(SETTLE_CYC - 1);
   localparam tmr_t  T_R    = tmr_t'(TURN90_CYC - 1);
   localparam tmr_t  T_L    = tmr_t'(2 * TURN90_CYC - 1);
   localparam dist_t OBST   = dist_t'(OBST_CM);
   localparam head_t BACK   = head_t'(-2 * TURN90_CYC);
   localparam head_t ONE    = head_t'(1);

   function automatic mot_t dir_f(head_t h, head_t t);
      mot_t m;
      unique case (1'b1)
         (h < t): m = MOT_RIGHT;
         (h > t): m = MOT_LEFT;
         default: m = MOT_STOP;
      endcase
      return m;
   endfunction

   logic   arm;
   state_t state_q;
   tmr_t   timer_q;
   head_t  head_q;
   head_t  tgt_q;
   head_t  bhead_q;
   dist_t  best_q;
   mot_t   motor_q;
   logic   active_q;
   logic   scan_q;

   logic   hit;
   dist_t  best_d;
   head_t  bhead_d;
   head_t  tgt_d;
   head_t  dec_d;
   head_t  step_d;

   motion_edge_sync u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (motion),
      .pulse_o (arm)
   );

   // Capture candidates include a sample arriving on the expiry cycle.
   always_comb begin
      hit     = bus.dist_valid && (bus.dist_cm > best_q);
      best_d  = hit ? bus.dist_cm : best_q;
      bhead_d = hit ? head_q : bhead_q;
      tgt_d   = (best_d >= OBST) ? bhead_d : BACK;
      dec_d   = head_q - ONE;
      step_d  = (head_q < tgt_q) ? head_q + ONE : head_q - ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         head_q   <= '0;
         tgt_q    <= '0;
         bhead_q  <= '0;
         best_q   <= '0;
         motor_q  <= MOT_STOP;
         active_q <= 1'b0;
         scan_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (arm) begin
                  state_q  <= FWD;
                  motor_q  <= MOT_FWD;
                  active_q <= 1'b1;
               end
            end
            FWD: begin
               if (bus.dist_valid && (bus.dist_cm < OBST)) begin
                  state_q <= SETTLE;
                  timer_q <= '0;
                  motor_q <= MOT_STOP;
               end
            end
            SETTLE: begin
               if (timer_q == T_SET) begin
                  state_q <= SCAN_R;
                  timer_q <= '0;
                  best_q  <= '0;
                  bhead_q <= '0;
                  head_q  <= '0;
                  motor_q <= MOT_RIGHT;
                  scan_q  <= 1'b1;
               end else begin
                  timer_q <= timer_q + tmr_t'(1);
               end
            end
            SCAN_R: begin
               best_q  <= best_d;
               bhead_q <= bhead_d;
               head_q  <= head_q + ONE;
               if (timer_q == T_R) begin
                  state_q <= SCAN_L;
                  timer_q <= '0;
                  motor_q <= MOT_LEFT;
               end else begin
                  timer_q <= timer_q + tmr_t'(1);
               end
            end
            SCAN_L: begin
               best_q  <= best_d;
               bhead_q <= bhead_d;
               head_q  <= dec_d;
               if (timer_q == T_L) begin
                  state_q <= ALIGN;
                  timer_q <= '0;
                  tgt_q   <= tgt_d;
                  motor_q <= dir_f(dec_d, tgt_d);
               end else begin
                  timer_q <= timer_q + tmr_t'(1);
               end
            end
            ALIGN: begin
               // Leave on the step that lands on target so no idle cycle follows.
               if ((head_q == tgt_q) || (step_d == tgt_q)) begin
                  state_q <= FWD;
                  head_q  <= '0;
                  motor_q <= MOT_FWD;
                  scan_q  <= 1'b0;
               end else begin
                  head_q  <= step_d;
                  motor_q <= dir_f(step_d, tgt_q);
               end
            end
            default: begin
               state_q <= IDLE;
               motor_q <= MOT_STOP;
            end
         endcase
      end
   end

   assign bus.motor_cmd = motor_q;
   assign bus.active    = active_q;
   assign bus.scanning  = scan_q;
   assign bus.best_dist = best_q;

endmodule

// File: tb/tb_obstacle_scan_ctrl.sv
// Randomized scoreboard bench for obstacle_scan_ctrl with a phase-level model.
module tb_obstacle_scan_ctrl;
   import robot_pkg::*;

   localparam int T90  = 100;
   localparam int SET  = 10;
   localparam int OBST = 25;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        motion = 1'b1;
   logic        dv = 1'b0;
   logic [15:0] dcm = '0;

   int checks = 0;
   int fails  = 0;

   obstacle_scan_ctrl_if #(.DIST_W(16)) bus ();

   assign bus.dist_valid = dv;
   assign bus.dist_cm    = dcm;

   obstacle_scan_ctrl #(
      .DIST_W     (16),
      .OBST_CM    (OBST),
      .TURN90_CYC (T90),
      .SETTLE_CYC (SET),
      .HEAD_W     (32)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .motion (motion),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef enum {M_IDLE, M_FWD, M_STOP, M_SWEEP, M_TURN} mmode_t;

   mmode_t      m_mode = M_IDLE;
   int          m_cnt = 0;
   int          m_rem = 0;
   int          m_bhead = 0;
   logic [1:0]  m_dir = 2'b00;
   logic [15:0] m_best = '0;
   bit          mh [5] = '{1, 1, 1, 1, 1};

   logic [19:0] expq [$];
   int          spos [$];
   logic [15:0] sval [$];
   logic [19:0] mon_e;
   logic [19:0] mon_a;

   function automatic logic [19:0] expv();
      logic [1:0] mo;
      mo = 2'b00;
      case (m_mode)
         M_FWD:   mo = 2'b11;
         M_SWEEP: mo = (m_cnt < T90) ? 2'b01 : 2'b10;
         M_TURN:  mo = (m_rem == 0) ? 2'b00 : m_dir;
         default: mo = 2'b00;
      endcase
      return {mo, m_mode != M_IDLE,
              (m_mode == M_SWEEP) || (m_mode == M_TURN), m_best};
   endfunction

   // Sweep is one 3*T90 phase: heading rises to T90 then falls to -T90.
   task automatic model_edge();
      int h;
      int tgt;
      if (!rst_n) begin
         m_mode = M_IDLE;
         m_cnt  = 0;
         m_rem  = 0;
         m_best = '0;
         m_bhead = 0;
         for (int i = 0; i < 5; i++) mh[i] = 1;
      end else begin
         for (int i = 0; i < 4; i++) mh[i] = mh[i+1];
         mh[4] = motion;
         case (m_mode)
            M_IDLE: if (mh[1] && !mh[0]) m_mode = M_FWD;
            M_FWD: begin
               if (dv && dcm < 16'(OBST)) begin
                  m_mode = M_STOP;
                  m_cnt  = 0;
               end
            end
            M_STOP: begin
               if (m_cnt == SET - 1) begin
                  m_mode  = M_SWEEP;
                  m_cnt   = 0;
                  m_best  = '0;
                  m_bhead = 0;
               end else m_cnt++;
            end
            M_SWEEP: begin
               h = (m_cnt < T90) ? m_cnt : 2 * T90 - m_cnt;
               if (dv && dcm > m_best) begin
                  m_best  = dcm;
                  m_bhead = h;
               end
               if (m_cnt == 3 * T90 - 1) begin
                  tgt    = (m_best >= 16'(OBST)) ? m_bhead : -2 * T90;
                  m_rem  = (tgt > -T90) ? tgt + T90 : -T90 - tgt;
                  m_dir  = (tgt > -T90) ? 2'b01 : 2'b10;
                  m_mode = M_TURN;
                  m_cnt  = 0;
               end else m_cnt++;
            end
            M_TURN: begin
               if (m_rem == 0) m_mode = M_FWD;
               else begin
                  m_rem--;
                  if (m_rem == 0) m_mode = M_FWD;
               end
            end
            default: m_mode = M_IDLE;
         endcase
      end
      expq.push_back(expv());
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            mon_a = {bus.motor_cmd, bus.active, bus.scanning, bus.best_dist};
            checks++;
            if (mon_a !== mon_e) begin
               fails++;
               $display("FAIL outputs t=%0t got mot=%b act=%b scan=%b best=%0d want mot=%b act=%b scan=%b best=%0d",
                        $time, mon_a[19:18], mon_a[17], mon_a[16], mon_a[15:0],
                        mon_e[19:18], mon_e[17], mon_e[16], mon_e[15:0]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic strobe(input logic [15:0] d);
      dv  = 1'b1;
      dcm = d;
      tick();
      dv  = 1'b0;
   endtask

   task automatic wait_for(input mmode_t md, input int c);
      int n;
      n = 0;
      while (!(m_mode == md && m_cnt == c) && n < 2000) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 2000) begin
         fails++;
         $display("FAIL wait_for got mode=%0d cnt=%0d want mode=%0d cnt=%0d",
                  m_mode, m_cnt, md, c);
      end
   endtask

   function automatic int find_pos(input int c);
      for (int i = 0; i < spos.size(); i++)
         if (spos[i] == c) return i;
      return -1;
   endfunction

   task automatic rand_samples(input int n, input int lo, input int hi);
      spos.delete();
      sval.delete();
      repeat (n) begin
         spos.push_back(int'($urandom_range(0, 3 * T90 - 1)));
         sval.push_back(16'($urandom_range(lo, hi)));
      end
   endtask

   task automatic obstacle(input logic [15:0] d);
      int k;
      wait_for(M_FWD, 0);
      strobe(d);
      while (m_mode == M_STOP) begin
         if ($urandom_range(0, 2) == 0) strobe(16'($urandom_range(0, 24)));
         else tick();
      end
      while (m_mode == M_SWEEP) begin
         k = find_pos(m_cnt);
         if (k >= 0) strobe(sval[k]);
         else tick();
      end
      while (m_mode == M_TURN) begin
         if ($urandom_range(0, 9) == 0) strobe(16'($urandom_range(0, 24)));
         else tick();
      end
   endtask

   initial begin
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (50) tick();
      motion = 1'b0;
      repeat (3) tick();
      motion = 1'b1;
      repeat (8) tick();
      strobe(16'd25);
      repeat (4) tick();
      repeat (10) begin
         strobe(16'($urandom_range(OBST, 1000)));
         repeat ($urandom_range(0, 3)) tick();
      end

      spos = '{30, 150, 200};
      sval = '{16'd40, 16'd90, 16'd90};
      obstacle(16'd24);
      repeat (5) tick();

      rand_samples(8, 0, 19);
      spos.push_front(int'($urandom_range(0, 3 * T90 - 1)));
      sval.push_front(16'd20);
      obstacle(16'd0);
      repeat (3) tick();

      spos = '{10, 99, 150, 250};
      sval = '{16'd100, 16'd300, 16'd300, 16'd299};
      obstacle(16'd7);
      repeat (3) tick();

      for (int s = 0; s < 3; s++) begin
         rand_samples(10, 0, 500);
         if (s == 1) begin
            spos.push_front(int'($urandom_range(0, 3 * T90 - 1)));
            sval.push_front(16'hFFFF);
         end
         obstacle(16'($urandom_range(0, OBST - 1)));
         repeat ($urandom_range(1, 5)) tick();
      end

      wait_for(M_FWD, 0);
      strobe(16'd10);
      wait_for(M_SWEEP, 150);
      rst_n = 1'b0;
      void'(expq.pop_back());
      expq.push_back(20'h0);
      #1;
      checks++;
      if ({bus.motor_cmd, bus.active, bus.best_dist} !== 19'h0) begin
         fails++;
         $display("FAIL async_reset got mot=%b act=%b best=%0d want mot=00 act=0 best=0",
                  bus.motor_cmd, bus.active, bus.best_dist);
      end
      repeat (4) tick();
      rst_n = 1'b1;
      repeat (30) tick();
      motion = 1'b0;
      repeat (2) tick();
      motion = 1'b1;
      repeat (8) tick();
      strobe(16'd30);
      repeat (3) tick();

      @(negedge clk);
      #1;
      checks++;
      if (expq.size() != 0) begin
         fails++;
         $display("FAIL drain got %0d pending want 0", expq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
